// File: rtl/apb_reg_bank_pkg.sv
// Shared constants for the APB register bank: register addresses, STATUS bit
// positions and the default ID byte.
package apb_reg_bank_pkg;

  localparam logic [7:0] ADDR_ID        = 8'h00;
  localparam logic [7:0] ADDR_SCRATCH   = 8'h01;
  localparam logic [7:0] ADDR_GPIO_OUT  = 8'h02;
  localparam logic [7:0] ADDR_GPIO_IN   = 8'h03;
  localparam logic [7:0] ADDR_FIFO_DATA = 8'h04;
  localparam logic [7:0] ADDR_STATUS    = 8'h05;
  localparam logic [7:0] ADDR_CNT_LO    = 8'h06;
  localparam logic [7:0] ADDR_CNT_HI    = 8'h07;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;
  localparam int STAT_UDF   = 3;

  localparam logic [7:0] ID_VALUE_DEFAULT = 8'hB8;

  function automatic logic [7:0] pack_status(input logic       empty,
                                             input logic       full,
                                             input logic       ovf,
                                             input logic       udf,
                                             input logic [3:0] count);
    logic [7:0] s;
    s             = {count, 4'b0000};
    s[STAT_EMPTY] = empty;
    s[STAT_FULL]  = full;
    s[STAT_OVF]   = ovf;
    s[STAT_UDF]   = udf;
    return s;
  endfunction

endpackage

// File: rtl/apb_reg_bank_if.sv
// APB bus bundle between the I2C-to-APB bridge (master) and the register bank (slave).
// Handshake: a transfer commits on the cycle PSEL & PENABLE & PREADY are all high.
interface apb_reg_bank_if;
  logic       PSEL;
  logic [7:0] PADDR;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;

  modport master (
    output PSEL, PADDR, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PSEL, PADDR, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/apb_reg_bank_byte_fifo.sv
// Byte-wide mailbox FIFO; DEPTH must be a power of two so pointers wrap for free.
// Push when full and pop when empty leave the contents and pointers untouched.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               din_i,
  output logic [7:0]               dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= din_i;
    end
  end
endmodule

// File: rtl/apb_reg_bank.sv
// APB slave register bank: ID, scratch, GPIO, byte mailbox, sticky status, cycle counter.
// Define APB_REG_BANK_WAIT_EN to insert one wait state (registered PRDATA) per access.
module apb_reg_bank
  import apb_reg_bank_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] ID_VALUE   = ID_VALUE_DEFAULT
) (
  input  logic           CLK,
  input  logic           RESETn,
  apb_reg_bank_if.slave  apb,
  input  logic [7:0]     gpio_i,
  output logic [7:0]     gpio_o,
  output logic           irq_o
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]       scratch_q, scratch_d;
  logic [7:0]       gpio_out_q, gpio_out_d;
  logic [7:0]       sync1_q, sync2_q;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [7:0]       shadow_q, shadow_d;
  logic             irq_q, irq_d;

  logic             access, pready, commit, wr_commit, rd_commit;
  logic [7:0]       rd_data, prdata, snap_hi;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_dout;
  logic [CNT_W-1:0] fifo_count;

  assign access    = apb.PSEL && apb.PENABLE;
  assign commit    = access && pready;
  assign wr_commit = commit && apb.PWRITE;
  assign rd_commit = commit && !apb.PWRITE;
  assign fifo_push = wr_commit && (apb.PADDR == ADDR_FIFO_DATA);
  assign fifo_pop  = rd_commit && (apb.PADDR == ADDR_FIFO_DATA);

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RESETn),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (apb.PWDATA),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Read mux always shows pre-commit state; side effects land on the commit edge.
  always_comb begin
    rd_data = 8'h00;
    case (apb.PADDR)
      ADDR_ID:        rd_data = ID_VALUE;
      ADDR_SCRATCH:   rd_data = scratch_q;
      ADDR_GPIO_OUT:  rd_data = gpio_out_q;
      ADDR_GPIO_IN:   rd_data = sync2_q;
      ADDR_FIFO_DATA: rd_data = fifo_empty ? 8'h00 : fifo_dout;
      ADDR_STATUS:    rd_data = pack_status(fifo_empty, fifo_full, ovf_q, udf_q, 4'(fifo_count));
      ADDR_CNT_LO:    rd_data = cnt_q[7:0];
      ADDR_CNT_HI:    rd_data = shadow_q;
      default:        rd_data = 8'h00;
    endcase
  end

`ifdef APB_REG_BANK_WAIT_EN
  logic       pready_q, pready_d;
  logic [7:0] prdata_q, prdata_d;
  logic [7:0] cap_hi_q, cap_hi_d;

  // First ACCESS cycle captures the read data (and the counter high byte that
  // pairs with it); the second cycle raises PREADY and commits.
  always_comb begin
    pready_d = 1'b0;
    prdata_d = 8'h00;
    cap_hi_d = cap_hi_q;
    if (access && !pready_q) begin
      pready_d = 1'b1;
      prdata_d = rd_data;
      cap_hi_d = cnt_q[15:8];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      pready_q <= 1'b0;
      prdata_q <= 8'h00;
      cap_hi_q <= 8'h00;
    end else begin
      pready_q <= pready_d;
      prdata_q <= prdata_d;
      cap_hi_q <= cap_hi_d;
    end
  end

  assign pready  = pready_q;
  assign prdata  = prdata_q;
  assign snap_hi = cap_hi_q;
`else
  assign pready  = 1'b1;
  assign prdata  = access ? rd_data : 8'h00;
  assign snap_hi = cnt_q[15:8];
`endif

  assign apb.PREADY = pready;
  assign apb.PRDATA = prdata;
  assign gpio_o     = gpio_out_q;
  assign irq_o      = irq_q;

  always_comb begin
    scratch_d  = scratch_q;
    gpio_out_d = gpio_out_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    shadow_d   = shadow_q;
    cnt_d      = cnt_q + 16'd1;
    if (fifo_push && fifo_full) ovf_d = 1'b1;
    if (fifo_pop && fifo_empty) udf_d = 1'b1;
    if (wr_commit) begin
      case (apb.PADDR)
        ADDR_SCRATCH:  scratch_d  = apb.PWDATA;
        ADDR_GPIO_OUT: gpio_out_d = apb.PWDATA;
        ADDR_STATUS: begin
          if (apb.PWDATA[STAT_OVF]) ovf_d = 1'b0;
          if (apb.PWDATA[STAT_UDF]) udf_d = 1'b0;
        end
        ADDR_CNT_LO:   cnt_d = 16'h0000;
        default:       ;
      endcase
    end
    if (rd_commit && (apb.PADDR == ADDR_CNT_LO)) shadow_d = snap_hi;
  end

  // irq_o tracks the FIFO occupancy that takes effect at this edge.
  always_comb begin
    irq_d = !fifo_empty;
    if (fifo_push && !fifo_full) irq_d = 1'b1;
    else if (fifo_pop && !fifo_empty && (fifo_count == CNT_W'(1))) irq_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      scratch_q  <= 8'h00;
      gpio_out_q <= 8'h00;
      sync1_q    <= 8'h00;
      sync2_q    <= 8'h00;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      cnt_q      <= 16'h0000;
      shadow_q   <= 8'h00;
      irq_q      <= 1'b0;
    end else begin
      scratch_q  <= scratch_d;
      gpio_out_q <= gpio_out_d;
      sync1_q    <= gpio_i;
      sync2_q    <= sync1_q;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      irq_q      <= irq_d;
    end
  end
endmodule
